mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the NJU_MIPS EX stage. Successor to the fixed 32-bit divider.
//  Adds shift-add multiply, signed/unsigned modes, MADD/MSUB accumulation into HI/LO, and a WIDTH generic.
//  EX issues an operation with start_i and stalls until ready_o. The {hi,lo} result feeds the hilo_reg write path.
// PARAMETERS
//  WIDTH     32   operand width; result is 2*WIDTH bits; must be >= 4
//  CNT_W     6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1        clock; all state changes on posedge
//  rst        in   1        reset, asynchronous, active-low (0 = reset)
//  start_i    in   1        request; sampled only in IDLE; held high by EX while stalled
//  annul_i    in   1        abort current operation (pipeline flush)
//  op_i       in   3        MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU
//  opdata1_i  in   WIDTH    multiplicand / dividend
//  opdata2_i  in   WIDTH    multiplier / divisor
//  hi_i,lo_i  in   WIDTH    accumulator for MADD/MSUB; forwarded HI/LO, sampled with start
//  result_o   out  2*WIDTH  {hi,lo}: mul -> {product}; div -> {remainder,quotient}
//  ready_o    out  1        result valid
//  busy_o     out  1        1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; result_o=0; ready_o=0; busy_o=0; counter and datapath regs cleared.
//  Operand latch on the start edge: op_i, operands, hi_i and lo_i are latched. Later changes are ignored.
//  Signed ops: magnitudes are latched, along with sign flags s1 and s2.
//  FSM:
//   IDLE  : start_i & !annul_i -> DIVZ if div op and opdata2_i==0, else CALC with cnt=0.
//   CALC  : one radix-2 step per cycle, cnt++. After WIDTH steps go to FIX.
//           Mul step: conditional add of the multiplicand, then shift right.
//           Div step: shift-subtract restoring.
//   FIX   : one cycle for sign correction and accumulate, then go to DONE.
//           Signed mul: negate the 2W product if s1^s2.
//           Signed div: quotient sign = s1^s2; remainder sign = s1.
//           MADD: {hi,lo} = acc + prod. MSUB: {hi,lo} = acc - prod. Both are 2W modular.
//   DIVZ  : {hi,lo} = {opdata1 raw, all-ones}, then go to DONE. No trap.
//   DONE  : ready_o=1, result_o stable. Go to IDLE when start_i==0. Stay while start_i==1 (stall held).
//  Latency:
//   normal op: ready_o rises WIDTH+2 cycles after the accepting edge (34 at WIDTH=32).
//   divide by zero: ready_o rises 2 cycles after the accepting edge.
//  annul_i=1 in any non-IDLE state: IDLE next cycle; ready_o=0; result_o keeps its old value.
//  annul_i=1 together with start_i in IDLE: request is not accepted.
//  Overflow: signed DIV of -2**(W-1) by -1 gives quotient 0x80..0 (wraps) and remainder 0.
//  result_o updates only on entry to DONE; it is held through IDLE until the next DONE.
//  Counter never wraps: CALC exits exactly when cnt==WIDTH-1 steps complete.
//  No operation is in progress after reset; a start accepted on the first edge after reset release is legal.
// STRUCTURE
//  Additions to macro.v (shared defines):
//   MDU op encodings MDU_MULT..MDU_MSUBU, 3 bits.
//   FSM state encodings: IDLE, CALC, FIX, DIVZ, DONE.
//  Single module with one optional sub-module, mdu_negate: combinational 2W-bit conditional two's complement.
//  mdu_negate is used for operand magnitude, product sign fix and accumulate-subtract.
//  Iteration datapath: one 2W+1-bit shift register shared by mul and div; one W+1-bit adder/subtractor.
// TESTING (WIDTH=32)
//  T1 DIVU 100/7 -> ready_o at edge +34; result_o={0x00000002,0x0000000E}.
//  T2 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  T3 MULT 0xFFFFFFFF*2 -> {0xFFFFFFFF,0xFFFFFFFE}.
//     MULTU same operands -> {0x00000001,0xFFFFFFFE}.
//  T4 MADD hi_i=0,lo_i=5, 3*4 -> {0,17}.
//     MSUBU hi_i=0,lo_i=5, 3*4 -> {0xFFFFFFFF,0xFFFFFFF9}.
//  T5 DIVU 9/0 -> ready_o at edge +2; result_o={0x00000009,0xFFFFFFFF}.
//     Hold start_i 5 more cycles -> ready_o stays 1; drop start_i -> IDLE next cycle.
//  T6 Annul at CALC cycle 10 -> busy_o=0 next cycle, ready_o never pulses.
//     Immediate new DIVU 100/7 -> correct result.
//     rst=0 mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared encodings and op-decode helpers for the iterative multiply/divide unit.
package mdu_iter_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MADD  = 3'd4,
      MDU_MADDU = 3'd5,
      MDU_MSUB  = 3'd6,
      MDU_MSUBU = 3'd7
   } mdu_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_FIX  = 3'd2,
      S_DIVZ = 3'd3,
      S_DONE = 3'd4
   } mdu_state_e;

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
   endfunction

   function automatic logic op_is_acc(input logic [2:0] op);
      return op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
   endfunction

   function automatic logic op_is_sub(input logic [2:0] op);
      return (op == MDU_MSUB) || (op == MDU_MSUBU);
   endfunction

endpackage

// File: rtl/mdu_iter_negate.sv
// Combinational conditional two's complement: y = en ? -a : a.
module mdu_iter_negate #(
   parameter int W = 64
) (
   input  logic         en_i,
   input  logic [W-1:0] a_i,
   output logic [W-1:0] y_o
);

   assign y_o = en_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with signed modes and HI/LO accumulate.
// state | meaning
// IDLE  | waiting for start_i; operands latched on acceptance
// CALC  | one shift-add (mul) or shift-subtract (div) step per cycle
// FIX   | sign correction and MADD/MSUB accumulation into result
// DIVZ  | divide by zero: result = {dividend, all-ones}
// DONE  | ready_o high, held until start_i drops
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic [2:0]         op_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic [WIDTH-1:0]   hi_i,
   input  logic [WIDTH-1:0]   lo_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   localparam int W2 = 2 * WIDTH;

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             s1_q, s1_d, s2_q, s2_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [W2:0]      sr_q, sr_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [W2-1:0]    result_q, result_d;

   logic             s1_in, s2_in;
   logic [WIDTH-1:0] mag1, mag2;

   assign s1_in = op_is_signed(op_i) & opdata1_i[WIDTH-1];
   assign s2_in = op_is_signed(op_i) & opdata2_i[WIDTH-1];

   mdu_iter_negate #(.W(WIDTH)) u_neg_op1 (.en_i(s1_in), .a_i(opdata1_i), .y_o(mag1));
   mdu_iter_negate #(.W(WIDTH)) u_neg_op2 (.en_i(s2_in), .a_i(opdata2_i), .y_o(mag2));

   // sr holds {partial(W+1), low word}; the one adder serves both mul and div
   logic [W2:0]      sr_shl;
   logic [WIDTH:0]   add_a;
   logic [WIDTH+1:0] add_y;
   logic [WIDTH:0]   mul_upper;
   logic [W2:0]      step_mul, step_div;

   assign sr_shl    = {sr_q[W2-1:0], 1'b0};
   assign add_a     = op_is_div(op_q) ? sr_shl[W2:WIDTH] : sr_q[W2:WIDTH];
   assign add_y     = op_is_div(op_q) ? ({1'b0, add_a} - {2'b00, opb_q})
                                      : ({1'b0, add_a} + {2'b00, opb_q});
   assign mul_upper = sr_q[0] ? add_y[WIDTH:0] : sr_q[W2:WIDTH];
   assign step_mul  = {1'b0, mul_upper, sr_q[WIDTH-1:1]};
   assign step_div  = add_y[WIDTH+1] ? sr_shl
                                     : {add_y[WIDTH:0], sr_shl[WIDTH-1:1], 1'b1};

   logic [W2-1:0]    prod_s, prod_t, mul_res;
   logic [WIDTH-1:0] quot_s, rem_s;

   mdu_iter_negate #(.W(W2)) u_neg_prod (
      .en_i(s1_q ^ s2_q), .a_i(sr_q[W2-1:0]), .y_o(prod_s));
   mdu_iter_negate #(.W(W2)) u_neg_acc (
      .en_i(op_is_sub(op_q)), .a_i(prod_s), .y_o(prod_t));
   mdu_iter_negate #(.W(WIDTH)) u_neg_quot (
      .en_i(s1_q ^ s2_q), .a_i(sr_q[WIDTH-1:0]), .y_o(quot_s));
   mdu_iter_negate #(.W(WIDTH)) u_neg_rem (
      .en_i(s1_q), .a_i(sr_q[W2-1:WIDTH]), .y_o(rem_s));

   assign mul_res = op_is_acc(op_q) ? (acc_q + prod_t) : prod_s;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      opb_d    = opb_q;
      sr_d     = sr_q;
      acc_d    = acc_q;
      result_d = result_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               op_d  = op_i;
               s1_d  = s1_in;
               s2_d  = s2_in;
               acc_d = {hi_i, lo_i};
               cnt_d = '0;
               if (op_is_div(op_i)) begin
                  opb_d = mag2;
                  if (opdata2_i == '0) begin
                     // raw dividend parked in the low word for the DIVZ result
                     sr_d    = {{(WIDTH+1){1'b0}}, opdata1_i};
                     state_d = S_DIVZ;
                  end else begin
                     sr_d    = {{(WIDTH+1){1'b0}}, mag1};
                     state_d = S_CALC;
                  end
               end else begin
                  opb_d   = mag1;
                  sr_d    = {{(WIDTH+1){1'b0}}, mag2};
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            sr_d  = op_is_div(op_q) ? step_div : step_mul;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            result_d = op_is_div(op_q) ? {rem_s, quot_s} : mul_res;
            state_d  = S_DONE;
         end
         S_DIVZ: begin
            result_d = {sr_q[WIDTH-1:0], {WIDTH{1'b1}}};
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (!start_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (annul_i && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         opb_q    <= '0;
         sr_q     <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         opb_q    <= opb_d;
         sr_q     <= sr_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = (state_q == S_DONE);
   assign busy_o   = (state_q != S_IDLE);

endmodule
